// File: rtl/tnn_stream_pkg.sv
// Shared constants and types for the TNN result stream path.
package tnn_stream_pkg;

  localparam int TNN_BEAT_W        = 512;
  localparam int TNN_BEATS_PER_IMG = 16;

  typedef logic [TNN_BEAT_W-1:0] tnn_beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_IMG = 1'b1
  } framer_state_e;

endpackage

// File: rtl/tnn_out_framer_if.sv
// Valid/ready result-beat bus: upstream beats in (s_*) and framed beats out (m_*).
interface tnn_out_framer_if
  import tnn_stream_pkg::*;
#(
  parameter int DATA_W = TNN_BEAT_W
);

  logic [DATA_W-1:0] s_bits;
  logic              s_vld;
  logic              s_rdy;
  logic [DATA_W-1:0] m_bits;
  logic              m_vld;
  logic              m_last;
  logic              m_rdy;

  // The framer sinks the s_* stream and sources the m_* stream.
  modport slave  (input  s_bits, s_vld, m_rdy, output s_rdy, m_bits, m_vld, m_last);
  modport master (output s_bits, s_vld, m_rdy, input  s_rdy, m_bits, m_vld, m_last);

endinterface

// File: rtl/tnn_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main output register plus one skid entry.
// in_rdy is registered (high iff the skid entry is empty) and gated low by clr.
module tnn_skid_buf #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             skid_vld
);

  logic             rdy_q;
  logic             main_vld;
  logic             skid_vld_q;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;

  assign in_rdy   = rdy_q & ~clr;
  assign in_fire  = in_vld & in_rdy;
  assign out_fire = main_vld & out_rdy;
  assign out_data = main_data;
  assign out_vld  = main_vld;
  assign skid_vld = skid_vld_q;

  // NOTE: main_data is reset only because the output beat must read zero out of
  // reset; skid_data is never observed while empty, so it stays unreset below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      main_vld   <= 1'b0;
      skid_vld_q <= 1'b0;
      main_data  <= '0;
    end else if (clr) begin
      rdy_q      <= 1'b1;
      main_vld   <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_fire || !main_vld) begin
      // Main register is free this cycle: refill from skid first to keep order.
      rdy_q <= 1'b1;
      if (skid_vld_q) begin
        main_data  <= skid_data;
        main_vld   <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        main_vld <= in_fire;
        if (in_fire) main_data <= in_data;
      end
    end else if (in_fire) begin
      skid_vld_q <= 1'b1;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= ~skid_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && main_vld && !out_fire) skid_data <= in_data;
  end

endmodule

// File: rtl/tnn_out_framer.sv
// Output framer: skid-buffers result beats, tags the last beat of each image,
// counts completed images and pulses img_done one cycle after each last beat.
module tnn_out_framer
  import tnn_stream_pkg::*;
#(
  parameter int DATA_W        = TNN_BEAT_W,
  parameter int BEATS_PER_IMG = TNN_BEATS_PER_IMG,
  parameter int CNT_W         = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  tnn_out_framer_if.slave     io,
  input  logic                flush,
  output logic [CNT_W-1:0]    img_cnt,
  output logic                img_done,
  output logic                busy
);

  localparam logic [15:0] LAST_IDX = 16'(BEATS_PER_IMG - 1);

  logic [15:0]   beat_idx;
  framer_state_e state;
  logic          skid_full;
  logic          last_beat;
  logic          out_hs;

  tnn_skid_buf #(.WIDTH(DATA_W)) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .clr      (flush),
    .in_data  (io.s_bits),
    .in_vld   (io.s_vld),
    .in_rdy   (io.s_rdy),
    .out_data (io.m_bits),
    .out_vld  (io.m_vld),
    .out_rdy  (io.m_rdy),
    .skid_vld (skid_full)
  );

  assign last_beat = (beat_idx == LAST_IDX);
  assign io.m_last = io.m_vld & last_beat;
  // A handshake that coincides with flush belongs to the aborted image.
  assign out_hs    = io.m_vld & io.m_rdy & ~flush;
  assign busy      = (state == IN_IMG) | io.m_vld | skid_full;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_idx <= '0;
      state    <= IDLE;
      img_cnt  <= '0;
      img_done <= 1'b0;
    end else if (flush) begin
      beat_idx <= '0;
      state    <= IDLE;
      img_done <= 1'b0;
    end else begin
      img_done <= out_hs & last_beat;
      if (out_hs) begin
        if (last_beat) begin
          beat_idx <= '0;
          state    <= IDLE;
          img_cnt  <= img_cnt + CNT_W'(1);
        end else begin
          beat_idx <= beat_idx + 16'd1;
          state    <= IN_IMG;
        end
      end
    end
  end

endmodule
